// File: rtl/fft_bfly_stage.sv
// fft_bfly_stage -- pipelined radix-2 DIT butterfly, two register stages.
//
// Takes the companion sample a and the twiddled product bw = b*W coming
// straight out of the complex multiplier, and produces
//    y0 = (a + bw)/2,  y1 = (a - bw)/2
// saturated to the DBW-bit sample range, ready for the next FFT stage.
//
// Ports (all complex buses packed {im, re}):
//    clk        rising-edge clock
//    rst_n      asynchronous active-low reset
//    in_valid   a/bw presented
//    in_ready   stage accepts a/bw this cycle
//    a          2*DBW, signed DBW per component
//    bw         4*DBW, signed 2*DBW per component (product in Q(DBW-1))
//    out_valid  y0/y1 valid
//    out_ready  downstream accepts y0/y1
//    y0, y1     2*DBW, signed DBW per component
//    ovf        sticky: some output component saturated
//    ovf_clr    synchronous clear of ovf (a same-cycle set wins)
//
// Build option: define BFLY_ROUND_EN to round half-up in the /2 scaling
// (add 1 before the shift). Without it the scaling truncates (floor).
// The bw alignment shift truncates in both builds.

module fft_bfly_stage #(
    parameter int DBW = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*DBW-1:0] a,
    input  logic [4*DBW-1:0] bw,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*DBW-1:0] y0,
    output logic [2*DBW-1:0] y1,
    output logic             ovf,
    input  logic             ovf_clr
);

    // Sum/difference width: a (DBW) plus aligned product (DBW+1) never
    // exceeds DBW+2 bits, including the rounding increment.
    localparam int SW = DBW + 2;
    localparam logic signed [SW-1:0] MAXV = SW'((1 << (DBW - 1)) - 1);
    localparam logic signed [SW-1:0] MINV = ~MAXV;

    // Returns {saturated, value[DBW-1:0]} for one halved component.
    function automatic logic [DBW:0] scale_sat(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] vr;
        logic signed [SW-1:0] sh;
        logic [DBW:0]         r;
`ifdef BFLY_ROUND_EN
        vr = v + SW'(1);
`else
        vr = v;
`endif
        sh = vr >>> 1;
        if (sh > MAXV) begin
            r = {1'b1, MAXV[DBW-1:0]};
        end else if (sh < MINV) begin
            r = {1'b1, MINV[DBW-1:0]};
        end else begin
            r = {1'b0, sh[DBW-1:0]};
        end
        return r;
    endfunction

    // Stage 1 registers
    logic             s1_valid_q, s1_valid_d;
    logic [2*DBW-1:0] s1_a_q, s1_a_d;
    logic [DBW:0]     s1_bs_re_q, s1_bs_re_d;
    logic [DBW:0]     s1_bs_im_q, s1_bs_im_d;

    // Stage 2 registers
    logic             s2_valid_q, s2_valid_d;
    logic [2*DBW-1:0] y0_q, y0_d;
    logic [2*DBW-1:0] y1_q, y1_d;
    logic             ovf_q, ovf_d;

    logic adv;
    logic accept;

    // The low DBW-1 bits of each product component fall off in the
    // Q(DBW-1) alignment.
    logic unused_bw;
    assign unused_bw = ^{bw[DBW-2:0], bw[3*DBW-2:2*DBW]};

    assign adv      = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || adv;
    assign accept   = in_valid && in_ready;

    logic signed [SW-1:0] a_re_x, a_im_x, bs_re_x, bs_im_x;
    logic signed [SW-1:0] sum_re, sum_im, dif_re, dif_im;
    logic [DBW:0]         r0_re, r0_im, r1_re, r1_im;
    logic                 sat_any;

    always_comb begin
        a_re_x  = {{2{s1_a_q[DBW-1]}}, s1_a_q[DBW-1:0]};
        a_im_x  = {{2{s1_a_q[2*DBW-1]}}, s1_a_q[2*DBW-1:DBW]};
        bs_re_x = {s1_bs_re_q[DBW], s1_bs_re_q};
        bs_im_x = {s1_bs_im_q[DBW], s1_bs_im_q};
        sum_re  = a_re_x + bs_re_x;
        sum_im  = a_im_x + bs_im_x;
        dif_re  = a_re_x - bs_re_x;
        dif_im  = a_im_x - bs_im_x;
        r0_re   = scale_sat(sum_re);
        r0_im   = scale_sat(sum_im);
        r1_re   = scale_sat(dif_re);
        r1_im   = scale_sat(dif_im);
        sat_any = r0_re[DBW] | r0_im[DBW] | r1_re[DBW] | r1_im[DBW];
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_bs_re_d = s1_bs_re_q;
        s1_bs_im_d = s1_bs_im_q;
        s2_valid_d = s2_valid_q;
        y0_d       = y0_q;
        y1_d       = y1_q;
        ovf_d      = ovf_q;

        // When in_ready is high stage 1 either is empty or is emptying
        // into stage 2 this cycle, so it simply takes in_valid.
        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (accept) begin
            s1_a_d     = a;
            s1_bs_re_d = bw[2*DBW-1:DBW-1];
            s1_bs_im_d = bw[4*DBW-1:3*DBW-1];
        end

        if (adv) begin
            s2_valid_d = s1_valid_q;
            // Only overwrite the outputs with real data so y0/y1 keep
            // their last value while the pipe runs dry.
            if (s1_valid_q) begin
                y0_d = {r0_im[DBW-1:0], r0_re[DBW-1:0]};
                y1_d = {r1_im[DBW-1:0], r1_re[DBW-1:0]};
            end
        end

        if (adv && s1_valid_q && sat_any) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_bs_re_q <= '0;
            s1_bs_im_q <= '0;
            s2_valid_q <= 1'b0;
            y0_q       <= '0;
            y1_q       <= '0;
            ovf_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_bs_re_q <= s1_bs_re_d;
            s1_bs_im_q <= s1_bs_im_d;
            s2_valid_q <= s2_valid_d;
            y0_q       <= y0_d;
            y1_q       <= y1_d;
            ovf_q      <= ovf_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign y0        = y0_q;
    assign y1        = y1_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_fft_bfly_stage.sv
// Self-checking bench for fft_bfly_stage (DBW = 3).
// Directed table vectors, multi-cycle corner sequences and a randomized
// phase, all scored against an integer-arithmetic butterfly model.

module tb_fft_bfly_stage;

    localparam int DBW  = 3;
    localparam int AMAX = (1 << (DBW - 1)) - 1;
    localparam int AMIN = -(1 << (DBW - 1));

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2*DBW-1:0] a;
    logic [4*DBW-1:0] bw;
    logic             out_valid;
    logic             out_ready;
    logic [2*DBW-1:0] y0;
    logic [2*DBW-1:0] y1;
    logic             ovf;
    logic             ovf_clr;

    fft_bfly_stage #(.DBW(DBW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .bw        (bw),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y0        (y0),
        .y1        (y1),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int are, aim, bre, bim;
        int y0re, y0im, y1re, y1im;
        int ovf;
    } vec_t;

    typedef struct {
        int y0re, y0im, y1re, y1im;
        int sat;
    } exp_t;

    int   n_cmp = 0;
    int   n_err = 0;
    vec_t tbl[5];
    exp_t sb[$];

    task automatic chk(input string nm, input logic signed [31:0] act,
                       input logic signed [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int fdiv(input int n, input int d);
        int q;
        q = n / d;
        if ((n % d) != 0 && ((n < 0) != (d < 0))) q = q - 1;
        return q;
    endfunction

    function automatic int halve_sat(input int v, output int sat);
        int r;
`ifdef BFLY_ROUND_EN
        r = fdiv(v + 1, 2);
`else
        r = fdiv(v, 2);
`endif
        sat = 0;
        if (r > AMAX) begin r = AMAX; sat = 1; end
        if (r < AMIN) begin r = AMIN; sat = 1; end
        return r;
    endfunction

    function automatic exp_t model(input int are, input int aim,
                                   input int bre, input int bim);
        exp_t e;
        int   bsr, bsi, s0, s1, s2, s3;
        bsr    = fdiv(bre, 1 << (DBW - 1));
        bsi    = fdiv(bim, 1 << (DBW - 1));
        e.y0re = halve_sat(are + bsr, s0);
        e.y0im = halve_sat(aim + bsi, s1);
        e.y1re = halve_sat(are - bsr, s2);
        e.y1im = halve_sat(aim - bsi, s3);
        e.sat  = s0 | s1 | s2 | s3;
        return e;
    endfunction

    function automatic int lo(input logic [2*DBW-1:0] v);
        return int'($signed(v[DBW-1:0]));
    endfunction

    function automatic int hi(input logic [2*DBW-1:0] v);
        return int'($signed(v[2*DBW-1:DBW]));
    endfunction

    task automatic set_in(input int are, input int aim, input int bre, input int bim);
        a  = {DBW'(aim), DBW'(are)};
        bw = {(2*DBW)'(bim), (2*DBW)'(bre)};
    endtask

    task automatic set_rand();
        set_in(int'($urandom_range(0, 7)) - 4, int'($urandom_range(0, 7)) - 4,
               int'($urandom_range(0, 63)) - 32, int'($urandom_range(0, 63)) - 32);
    endtask

    // ---------------- scoreboard monitor ----------------
    // Handshakes are sampled at the falling edge; they commit on the next
    // rising edge.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                chk("sb_has_entry", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("sb_y0_re", lo(y0), e.y0re);
                    chk("sb_y0_im", hi(y0), e.y0im);
                    chk("sb_y1_re", lo(y1), e.y1re);
                    chk("sb_y1_im", hi(y1), e.y1im);
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(lo(a), hi(a), int'($signed(bw[2*DBW-1:0])),
                                   int'($signed(bw[4*DBW-1:2*DBW]))));
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    task automatic clear_ovf();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_cleared", ovf, 0);
    endtask

    // One beat into an idle pipe with out_ready=1: checks latency and data.
    task automatic one_beat(input vec_t v, input string tag);
        set_in(v.are, v.aim, v.bre, v.bim);
        in_valid = 1'b1;
        chk({tag, "_in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk({tag, "_lat1_out_valid"}, out_valid, 0);
        tick();
        chk({tag, "_lat2_out_valid"}, out_valid, 1);
        chk({tag, "_y0_re"}, lo(y0), v.y0re);
        chk({tag, "_y0_im"}, hi(y0), v.y0im);
        chk({tag, "_y1_re"}, lo(y1), v.y1re);
        chk({tag, "_y1_im"}, hi(y1), v.y1im);
        chk({tag, "_ovf"}, ovf, v.ovf);
        tick();
        chk({tag, "_popped"}, out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e0, e1;
        int   cnt, first, last, acc, cyc;
        bit   have;

        // {are, aim, bre, bim, y0re, y0im, y1re, y1im, ovf}
`ifdef BFLY_ROUND_EN
        tbl[0] = '{2, 0, 6, 0, 2, 0, 1, 0, 0};
        tbl[3] = '{1, -1, 3, -5, 1, -1, 1, 1, 0};
        tbl[4] = '{-1, 2, -1, 7, -1, 2, 0, 1, 0};
`else
        tbl[0] = '{2, 0, 6, 0, 1, 0, 0, 0, 0};
        tbl[3] = '{1, -1, 3, -5, 0, -2, 0, 0, 0};
        tbl[4] = '{-1, 2, -1, 7, -1, 1, 0, 0, 0};
`endif
        tbl[1] = '{3, 0, 28, 0, 3, 0, -2, 0, 1};
        tbl[2] = '{-4, -4, -32, -32, -4, -4, 2, 2, 1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ovf_clr   = 1'b0;
        a         = '0;
        bw        = '0;

        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y0", y0, 0);
        chk("rst_y1", y1, 0);
        chk("rst_ovf", ovf, 0);
        #9 rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", in_ready, 1);

        // Directed table; ovf must stay sticky until cleared.
        for (int i = 0; i < 5; i++) begin
            one_beat(tbl[i], $sformatf("tbl%0d", i));
            tick();
            tick();
            chk($sformatf("tbl%0d_ovf_sticky", i), ovf, tbl[i].ovf);
            clear_ovf();
        end

        // ovf_clr in the same cycle a saturating result loads: set wins.
        set_in(tbl[1].are, tbl[1].aim, tbl[1].bre, tbl[1].bim);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        ovf_clr  = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("clr_vs_set_ovf", ovf, 1);
        chk("clr_vs_set_out_valid", out_valid, 1);
        tick();
        clear_ovf();

        // 8-beat stream at full rate.
        cnt = 0; first = -1; last = -1;
        for (int c = 0; c < 14; c++) begin
            if (out_valid) begin
                cnt++;
                if (first < 0) first = c;
                last = c;
            end
            if (c < 8) begin
                set_rand();
                in_valid = 1'b1;
                chk($sformatf("stream_in_ready%0d", c), in_ready, 1);
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        chk("stream_count", cnt, 8);
        chk("stream_first", first, 2);
        chk("stream_contiguous", last - first, 7);
        drain();
        clear_ovf();

        // Backpressure: 2 beats fill the pipe, third waits.
        out_ready = 1'b0;
        set_in(1, 2, 10, -9);
        e0 = model(1, 2, 10, -9);
        in_valid = 1'b1;
        chk("bp_in_ready0", in_ready, 1);
        tick();
        set_in(-3, 1, -20, 5);
        chk("bp_in_ready1", in_ready, 1);
        tick();
        set_in(0, -2, 13, 2);
        chk("bp_full_in_ready", in_ready, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("bp_hold_in_ready%0d", k), in_ready, 0);
            chk($sformatf("bp_hold_out_valid%0d", k), out_valid, 1);
            chk($sformatf("bp_hold_y0_re%0d", k), lo(y0), e0.y0re);
            chk($sformatf("bp_hold_y0_im%0d", k), hi(y0), e0.y0im);
            chk($sformatf("bp_hold_y1_re%0d", k), lo(y1), e0.y1re);
            chk($sformatf("bp_hold_y1_im%0d", k), hi(y1), e0.y1im);
        end
        chk("bp_sb_depth", sb.size(), 2);
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        drain();
        clear_ovf();

        // Asynchronous reset with two beats in flight.
        out_ready = 1'b0;
        set_in(tbl[1].are, tbl[1].aim, tbl[1].bre, tbl[1].bim);
        in_valid = 1'b1;
        tick();
        set_in(2, 3, 14, 17);
        tick();
        in_valid = 1'b0;
        chk("pre_rst_ovf", ovf, 1);
        chk("pre_rst_out_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_y0", y0, 0);
        chk("async_rst_y1", y1, 0);
        chk("async_rst_ovf", ovf, 0);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("rel_in_ready", in_ready, 1);
        chk("rel_out_valid", out_valid, 0);
        tick();
        chk("rel_no_stale", out_valid, 0);
        one_beat(tbl[0], "after_rst");

        // Randomized traffic with random backpressure.
        acc = 0; cyc = 0; have = 1'b0;
        while (acc < 300 && cyc < 5000) begin
            if (!have && $urandom_range(0, 3) != 0) begin
                set_rand();
                have = 1'b1;
            end
            in_valid  = have;
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (have && in_ready) begin
                have = 1'b0;
                acc++;
            end
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("rand_accepted", acc, 300);
        drain();
        tick();
        chk("final_out_valid", out_valid, 0);

        e1 = model(3, 0, 28, 0);
        chk("model_sanity_sat", e1.sat, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
